issue_queue_wakeup: RTL and testbench
=====================================

# issue_queue_wakeup

Parametrised issue queue that sits between the issue stage and execute. It holds up to DEPTH renamed instructions, each with destination and two source physical-register tags plus per-source ready bits. It wakes entries from WAKE_PORTS result-tag broadcasts and selects one fully ready entry per cycle for dispatch. It adds capacity, operand-readiness tracking, out-of-order selection and a downstream handshake to the single-entry pass-through issue path.

## Interface
Parameters:
- PAYLOAD_W, 160, opaque instruction payload width carried unchanged to the output
- TAG_W, 6, physical register tag width
- DEPTH, 8, entry count; power of two, 2..32
- WAKE_PORTS, 2, number of result-tag broadcast ports

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-high; clears all entries
- FREEZE  in  1  stall: blocks allocate and issue; wakeup still applied
- flush  in  1  synchronous clear of all entries (mispredict or commit flush)
- in_valid  in  1  allocate request
- in_ready  out  1  queue can accept (count < DEPTH)
- in_dest  in  TAG_W  destination tag
- in_srcA, in_srcB  in  TAG_W  source tags
- in_readyA, in_readyB  in  1  source already available at allocate
- in_payload  in  PAYLOAD_W  payload
- wake_valid  in  WAKE_PORTS  per-port broadcast valid
- wake_tag  in  WAKE_PORTS*TAG_W  packed broadcast tags, port 0 in LSBs
- issue_valid  out  1  a selected entry is presented
- issue_ready  in  1  downstream accepts this cycle
- issue_dest  out  TAG_W  selected entry destination tag
- issue_payload  out  PAYLOAD_W  selected entry payload
- issue_slot  out  $clog2(DEPTH)  index of selected entry
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Entry state: valid, dest, srcA, rdyA, srcB, rdyB, payload. RESET clears all valid and ready bits, count = 0. Tags and payload are don't-care when invalid.
- Allocate fires when in_valid && in_ready && !FREEZE. It writes the lowest-index invalid slot.
- Wakeup: on each edge, every valid entry sets rdyA if any wake_valid[p] is high with wake_tag[p] == srcA; the same rule applies to rdyB. Ready bits never clear except on entry release.
- Allocate bypass: an incoming source whose tag matches a same-cycle valid broadcast is stored as ready, even if in_readyX = 0.
- Select is combinational from registered state. It takes the lowest-index entry with valid && rdyA && rdyB.
  - issue_valid = found && !FREEZE.
  - issue_dest, issue_payload and issue_slot show the selected entry. They are 0 when issue_valid = 0.
- Issue fires on issue_valid && issue_ready. The selected entry's valid bit clears at the edge.
- count update: count += (alloc fire) - (issue fire).
- flush (sync) and RESET (async) clear all entries and count. flush takes priority over a same-cycle allocate, issue or wakeup.
- FREEZE: no allocate, no issue, no count change. Wakeups are still recorded.
- Tag compare is exact over TAG_W bits. Tag 0 gets no special treatment; the producer asserts in_readyX for it.

## Timing
- Allocate at edge N. The entry can appear on issue_valid in cycle N+1 if both sources are ready at allocate, including via bypass.
- Wakeup broadcast in cycle N makes the entry selectable from cycle N+1. There is no same-cycle wake-to-issue.
- Issue: entry held while issue_ready = 0. Output stays stable unless a lower-index entry becomes ready, which may replace the presented selection. This is allowed; downstream must not assume stickiness.
- Full: in_ready = 0 when count == DEPTH, even if an issue fires the same cycle. There is no same-cycle slot reuse.
- A slot freed at edge N is allocatable from cycle N (after the edge).
- RESET asserted mid-operation: all outputs go to 0 immediately (in_ready = 1, count = 0, issue_valid = 0).
- Allocate and issue in the same cycle always target different slots, because the allocate slot is invalid and the selected slot is valid.

## Test plan
- Reset and basic allocate/issue:
  - Stimulus: reset, then allocate dest=5, srcA=1 rdyA=1, srcB=2 rdyB=1, payload=0xABC with issue_ready=1.
  - Required: issue_valid=1 the next cycle, issue_dest=5, payload 0xABC, slot 0; count 1 then 0.
- Wakeup:
  - Stimulus: allocate srcA=3 rdyA=0, srcB=4 rdyB=1. Issue stays low. Then wake_tag[0]=3 with valid.
  - Required: issue_valid=1 exactly one cycle later.
- Bypass:
  - Stimulus: allocate srcA=7 rdyA=0 in the same cycle that wake port 1 broadcasts 7.
  - Required: entry issues the next cycle.
- Full and ordering:
  - Stimulus: fill DEPTH=8 entries, none ready.
  - Required: in_ready=0 and count=8. Wake only slot 5's source, then issue_slot=5. Wake slots 2 and 6 together, then slot 2 issues first, then 6.
- Backpressure and FREEZE:
  - Stimulus: a ready entry with issue_ready=0 for 3 cycles.
  - Required: held with stable outputs and count unchanged. With FREEZE=1, issue_valid=0 and allocate is ignored, but a wakeup during FREEZE is visible after release.
- Flush and reset:
  - Stimulus: 4 entries valid, then flush alongside allocate and issue.
  - Required: count=0 and issue_valid=0 the next cycle. Asserting RESET between edges zeroes the outputs immediately.

Source files
------------

// File: rtl/issue_queue_wakeup.sv
// issue_queue_wakeup
// Out-of-order issue queue. Entries are written into the lowest free slot.
// Operand ready bits are set by result-tag broadcasts. Each cycle the
// lowest-index entry with both operands ready is presented downstream.
module issue_queue_wakeup #(
    parameter int PAYLOAD_W  = 160,
    parameter int TAG_W      = 6,
    parameter int DEPTH      = 8,
    parameter int WAKE_PORTS = 2
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          FREEZE,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [TAG_W-1:0]              in_dest,
    input  logic [TAG_W-1:0]              in_srcA,
    input  logic [TAG_W-1:0]              in_srcB,
    input  logic                          in_readyA,
    input  logic                          in_readyB,
    input  logic [PAYLOAD_W-1:0]          in_payload,
    input  logic [WAKE_PORTS-1:0]         wake_valid,
    input  logic [WAKE_PORTS*TAG_W-1:0]   wake_tag,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [TAG_W-1:0]              issue_dest,
    output logic [PAYLOAD_W-1:0]          issue_payload,
    output logic [$clog2(DEPTH)-1:0]      issue_slot,
    output logic [$clog2(DEPTH):0]        count
);

    localparam int SLOT_W = $clog2(DEPTH);
    localparam int CNT_W  = SLOT_W + 1;

    // Entry storage
    logic [DEPTH-1:0]     valid_r;
    logic [DEPTH-1:0]     rdy_a_r;
    logic [DEPTH-1:0]     rdy_b_r;
    logic [TAG_W-1:0]     dest_r    [DEPTH];
    logic [TAG_W-1:0]     src_a_r   [DEPTH];
    logic [TAG_W-1:0]     src_b_r   [DEPTH];
    logic [PAYLOAD_W-1:0] payload_r [DEPTH];
    logic [CNT_W-1:0]     count_r;

    // Combinational helpers
    logic [DEPTH-1:0]     wake_a_s;
    logic [DEPTH-1:0]     wake_b_s;
    logic                 byp_a_s;
    logic                 byp_b_s;
    logic                 sel_found_s;
    logic [SLOT_W-1:0]    sel_slot_s;
    logic [SLOT_W-1:0]    free_slot_s;
    logic                 alloc_fire_s;
    logic                 issue_fire_s;

    // True when any valid broadcast carries exactly this tag
    function automatic logic tag_hit(
        input logic [TAG_W-1:0]            tag,
        input logic [WAKE_PORTS-1:0]       wv,
        input logic [WAKE_PORTS*TAG_W-1:0] wt
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WAKE_PORTS; p++) begin
            if (wv[p] && (wt[p*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

    // Broadcast matches against stored sources and against the incoming sources (bypass)
    always_comb begin
        wake_a_s = '0;
        wake_b_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wake_a_s[i] = tag_hit(src_a_r[i], wake_valid, wake_tag);
            wake_b_s[i] = tag_hit(src_b_r[i], wake_valid, wake_tag);
        end
        byp_a_s = in_readyA | tag_hit(in_srcA, wake_valid, wake_tag);
        byp_b_s = in_readyB | tag_hit(in_srcB, wake_valid, wake_tag);
    end

    // Lowest-index ready entry for issue and lowest-index free slot for allocate
    always_comb begin
        sel_found_s = 1'b0;
        sel_slot_s  = '0;
        free_slot_s = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_r[i] && rdy_a_r[i] && rdy_b_r[i]) begin
                sel_found_s = 1'b1;
                sel_slot_s  = SLOT_W'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
            if (!valid_r[i]) begin
                free_slot_s = SLOT_W'(i);
            end else begin
                free_slot_s = free_slot_s;
            end
        end
    end

    // Handshake qualification; a full queue refuses input even while issuing
    always_comb begin
        in_ready     = (count_r < CNT_W'(DEPTH));
        issue_valid  = sel_found_s && !FREEZE;
        alloc_fire_s = in_valid && in_ready && !FREEZE;
        issue_fire_s = issue_valid && issue_ready;
    end

    // Presented entry; zeroed whenever nothing is offered
    always_comb begin
        if (issue_valid) begin
            issue_dest    = dest_r[sel_slot_s];
            issue_payload = payload_r[sel_slot_s];
            issue_slot    = sel_slot_s;
        end else begin
            issue_dest    = '0;
            issue_payload = '0;
            issue_slot    = '0;
        end
        count = count_r;
    end

    // Entry state: flush wins over everything; otherwise wakeup, release, allocate
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid_r <= '0;
            rdy_a_r <= '0;
            rdy_b_r <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dest_r[i]    <= '0;
                src_a_r[i]   <= '0;
                src_b_r[i]   <= '0;
                payload_r[i] <= '0;
            end
        end else if (flush) begin
            valid_r <= '0;
            rdy_a_r <= '0;
            rdy_b_r <= '0;
            count_r <= '0;
        end else begin
            // Wakeups are recorded even while frozen
            rdy_a_r <= rdy_a_r | (valid_r & wake_a_s);
            rdy_b_r <= rdy_b_r | (valid_r & wake_b_s);
            // Allocate and issue never target the same slot
            if (issue_fire_s) begin
                valid_r[sel_slot_s] <= 1'b0;
            end
            if (alloc_fire_s) begin
                valid_r[free_slot_s]   <= 1'b1;
                rdy_a_r[free_slot_s]   <= byp_a_s;
                rdy_b_r[free_slot_s]   <= byp_b_s;
                dest_r[free_slot_s]    <= in_dest;
                src_a_r[free_slot_s]   <= in_srcA;
                src_b_r[free_slot_s]   <= in_srcB;
                payload_r[free_slot_s] <= in_payload;
            end
            count_r <= count_r + CNT_W'(alloc_fire_s) - CNT_W'(issue_fire_s);
        end
    end

endmodule

// File: tb/tb_issue_queue_wakeup.sv
// Directed bench for issue_queue_wakeup (default parameters).
module tb_issue_queue_wakeup;

    logic         CLK = 1'b0;
    logic         RESET, FREEZE, flush;
    logic         in_valid, in_ready;
    logic [5:0]   in_dest, in_srcA, in_srcB;
    logic         in_readyA, in_readyB;
    logic [159:0] in_payload;
    logic [1:0]   wake_valid;
    logic [11:0]  wake_tag;
    logic         issue_valid, issue_ready;
    logic [5:0]   issue_dest;
    logic [159:0] issue_payload;
    logic [2:0]   issue_slot;
    logic [3:0]   count;

    int checks   = 0;
    int failures = 0;

    issue_queue_wakeup dut (
        .CLK(CLK), .RESET(RESET), .FREEZE(FREEZE), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_dest(in_dest),
        .in_srcA(in_srcA), .in_srcB(in_srcB), .in_readyA(in_readyA), .in_readyB(in_readyB),
        .in_payload(in_payload), .wake_valid(wake_valid), .wake_tag(wake_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_dest(issue_dest),
        .issue_payload(issue_payload), .issue_slot(issue_slot), .count(count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_readyA  = 1'b0;
        in_readyB  = 1'b0;
        wake_valid = 2'b00;
        wake_tag   = 12'h000;
        flush      = 1'b0;
    endtask

    task automatic set_alloc(input logic [5:0] d, input logic [5:0] sa, input logic ra,
                             input logic [5:0] sb, input logic rb, input logic [159:0] pl);
        in_valid   = 1'b1;
        in_dest    = d;
        in_srcA    = sa;
        in_readyA  = ra;
        in_srcB    = sb;
        in_readyB  = rb;
        in_payload = pl;
    endtask

    task automatic test_reset();
        RESET = 1'b1; FREEZE = 1'b0; issue_ready = 1'b0;
        in_dest = 6'd0; in_srcA = 6'd0; in_srcB = 6'd0; in_payload = 160'h0;
        idle();
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL reset_issue_valid got=%0b exp=0", issue_valid); end
        RESET = 1'b0;
    endtask

    task automatic test_basic();
        issue_ready = 1'b1;
        set_alloc(6'd5, 6'd1, 1'b1, 6'd2, 1'b1, 160'hABC);
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL basic_pre_valid got=%0b exp=0", issue_valid); end
        tick(); idle();
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", issue_valid); end
        checks++; if (issue_dest !== 6'd5) begin failures++; $display("FAIL basic_dest got=%0d exp=5", issue_dest); end
        checks++; if (issue_payload !== 160'hABC) begin failures++; $display("FAIL basic_payload got=%0h exp=abc", issue_payload); end
        checks++; if (issue_slot !== 3'd0) begin failures++; $display("FAIL basic_slot got=%0d exp=0", issue_slot); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL basic_count1 got=%0d exp=1", count); end
        tick();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL basic_count0 got=%0d exp=0", count); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%0b exp=0", issue_valid); end
    endtask

    task automatic test_wakeup();
        issue_ready = 1'b1;
        set_alloc(6'd9, 6'd3, 1'b0, 6'd4, 1'b1, 160'h99);
        tick(); idle();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_wait1 got=%0b exp=0", issue_valid); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL wake_count got=%0d exp=1", count); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_wait2 got=%0b exp=0", issue_valid); end
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd3};
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL wake_same_cycle got=%0b exp=0", issue_valid); end
        tick(); idle();
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL wake_issue got=%0b exp=1", issue_valid); end
        checks++; if (issue_dest !== 6'd9) begin failures++; $display("FAIL wake_dest got=%0d exp=9", issue_dest); end
        tick();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL wake_drain got=%0d exp=0", count); end
    endtask

    task automatic test_bypass();
        issue_ready = 1'b1;
        set_alloc(6'd11, 6'd7, 1'b0, 6'd8, 1'b1, 160'h711);
        wake_valid = 2'b10; wake_tag = {6'd7, 6'd0};
        tick(); idle();
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL bypass_valid got=%0b exp=1", issue_valid); end
        checks++; if (issue_dest !== 6'd11) begin failures++; $display("FAIL bypass_dest got=%0d exp=11", issue_dest); end
        tick();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL bypass_drain got=%0d exp=0", count); end
    endtask

    task automatic test_full_order();
        issue_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_alloc(6'(20 + i), 6'(32 + i), 1'b0, 6'd1, 1'b1, 160'(i));
            tick();
        end
        idle();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_count got=%0d exp=8", count); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL full_none_ready got=%0b exp=0", issue_valid); end
        // Allocate attempt while full is dropped
        set_alloc(6'd63, 6'd1, 1'b1, 6'd1, 1'b1, 160'h0);
        tick(); idle();
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL full_drop got=%0d exp=8", count); end
        // Wake only slot 5
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd37};
        tick(); idle();
        checks++; if (issue_slot !== 3'd5) begin failures++; $display("FAIL order_slot5 got=%0d exp=5", issue_slot); end
        checks++; if (issue_dest !== 6'd25) begin failures++; $display("FAIL order_dest25 got=%0d exp=25", issue_dest); end
        // Issue while full: still no same-cycle allocation
        set_alloc(6'd62, 6'd1, 1'b1, 6'd1, 1'b1, 160'h0);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_issue_in_ready got=%0b exp=0", in_ready); end
        tick(); idle();
        checks++; if (count !== 4'd7) begin failures++; $display("FAIL full_issue_count got=%0d exp=7", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL freed_in_ready got=%0b exp=1", in_ready); end
        // Freed slot 5 is reused immediately
        set_alloc(6'd40, 6'd50, 1'b1, 6'd51, 1'b1, 160'h40);
        tick(); idle();
        checks++; if (issue_slot !== 3'd5) begin failures++; $display("FAIL reuse_slot got=%0d exp=5", issue_slot); end
        checks++; if (issue_dest !== 6'd40) begin failures++; $display("FAIL reuse_dest got=%0d exp=40", issue_dest); end
        checks++; if (count !== 4'd8) begin failures++; $display("FAIL reuse_count got=%0d exp=8", count); end
        tick();
        checks++; if (count !== 4'd7) begin failures++; $display("FAIL reuse_issued got=%0d exp=7", count); end
        // Wake slots 2 and 6 together: lower index first
        wake_valid = 2'b11; wake_tag = {6'd38, 6'd34};
        tick(); idle();
        checks++; if (issue_slot !== 3'd2) begin failures++; $display("FAIL order_slot2 got=%0d exp=2", issue_slot); end
        checks++; if (issue_dest !== 6'd22) begin failures++; $display("FAIL order_dest22 got=%0d exp=22", issue_dest); end
        tick();
        checks++; if (issue_slot !== 3'd6) begin failures++; $display("FAIL order_slot6 got=%0d exp=6", issue_slot); end
        checks++; if (issue_dest !== 6'd26) begin failures++; $display("FAIL order_dest26 got=%0d exp=26", issue_dest); end
        checks++; if (count !== 4'd6) begin failures++; $display("FAIL order_count6 got=%0d exp=6", count); end
        tick();
        checks++; if (count !== 4'd5) begin failures++; $display("FAIL order_count5 got=%0d exp=5", count); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL order_empty_sel got=%0b exp=0", issue_valid); end
        flush = 1'b1;
        tick(); idle();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL order_cleanup got=%0d exp=0", count); end
    endtask

    task automatic test_backpressure_freeze();
        issue_ready = 1'b0;
        set_alloc(6'd13, 6'd1, 1'b1, 6'd1, 1'b1, 160'h123);
        tick();
        set_alloc(6'd14, 6'd45, 1'b0, 6'd46, 1'b1, 160'h456);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%0b exp=1", issue_valid); end
            checks++; if (issue_dest !== 6'd13) begin failures++; $display("FAIL hold_dest got=%0d exp=13", issue_dest); end
            checks++; if (issue_payload !== 160'h123) begin failures++; $display("FAIL hold_payload got=%0h exp=123", issue_payload); end
            checks++; if (count !== 4'd2) begin failures++; $display("FAIL hold_count got=%0d exp=2", count); end
            tick();
        end
        FREEZE = 1'b1; issue_ready = 1'b1;
        set_alloc(6'd15, 6'd1, 1'b1, 6'd1, 1'b1, 160'h789);
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd45};
        #1;
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL freeze_valid got=%0b exp=0", issue_valid); end
        checks++; if (issue_dest !== 6'd0) begin failures++; $display("FAIL freeze_dest got=%0d exp=0", issue_dest); end
        tick(); idle();
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL freeze_count got=%0d exp=2", count); end
        FREEZE = 1'b0;
        #1;
        checks++; if (issue_slot !== 3'd0) begin failures++; $display("FAIL unfreeze_slot got=%0d exp=0", issue_slot); end
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL unfreeze_valid got=%0b exp=1", issue_valid); end
        tick();
        checks++; if (issue_slot !== 3'd1) begin failures++; $display("FAIL freeze_wake_slot got=%0d exp=1", issue_slot); end
        checks++; if (issue_dest !== 6'd14) begin failures++; $display("FAIL freeze_wake_dest got=%0d exp=14", issue_dest); end
        checks++; if (count !== 4'd1) begin failures++; $display("FAIL freeze_wake_count got=%0d exp=1", count); end
        tick();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL freeze_drain got=%0d exp=0", count); end
    endtask

    task automatic test_flush();
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_alloc(6'(50 + i), 6'd10, (i == 0), 6'd10, 1'b1, 160'(i));
            tick();
        end
        idle();
        checks++; if (count !== 4'd4) begin failures++; $display("FAIL flush_pre_count got=%0d exp=4", count); end
        checks++; if (issue_valid !== 1'b1) begin failures++; $display("FAIL flush_pre_valid got=%0b exp=1", issue_valid); end
        flush = 1'b1; issue_ready = 1'b1;
        set_alloc(6'd60, 6'd1, 1'b1, 6'd1, 1'b1, 160'h60);
        wake_valid = 2'b01; wake_tag = {6'd0, 6'd10};
        tick(); idle();
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b exp=0", issue_valid); end
        tick();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL flush_after got=%0b exp=0", issue_valid); end
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b0;
        set_alloc(6'd30, 6'd1, 1'b1, 6'd1, 1'b1, 160'h30);
        tick();
        set_alloc(6'd31, 6'd1, 1'b1, 6'd1, 1'b1, 160'h31);
        tick(); idle();
        checks++; if (count !== 4'd2) begin failures++; $display("FAIL rmid_pre_count got=%0d exp=2", count); end
        #2 RESET = 1'b1;
        #1;
        checks++; if (count !== 4'd0) begin failures++; $display("FAIL rmid_count got=%0d exp=0", count); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready got=%0b exp=1", in_ready); end
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%0b exp=0", issue_valid); end
        checks++; if (issue_dest !== 6'd0) begin failures++; $display("FAIL rmid_dest got=%0d exp=0", issue_dest); end
        #1 RESET = 1'b0;
        tick();
        checks++; if (issue_valid !== 1'b0) begin failures++; $display("FAIL rmid_after got=%0b exp=0", issue_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full_order();
        test_backpressure_freeze();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
